pipe_stall_ctrl: RTL and testbench

// - Consumer side of the load-use hazard detector. Turns the stall request, a branch-redirect flush and a data-memory busy handshake into pipeline controls.
// - Owns the IF/ID pipeline register. Drives PC write-enable and the ID/EX bubble insert.
// - Sits between the IF stage, the hazard detector (ID) and the EX/MEM stages of the 5-stage RV32I core.

---
 rtl/core_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 43 ++++
 rtl/pipe_stall_ctrl.sv | 108 ++++++++++
 tb/tb_pipe_stall_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: PC width, the injected NOP and stall-controller encodings.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_LU  = 2'd1,
    ST_FRZ = 2'd2
  } stall_state_t;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_FLUSH = 2'd2
  } if_id_op_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold, load from fetch, or flush to an invalid NOP.
module if_id_reg
  import core_pkg::*;
#(
  parameter int unsigned XLEN = core_pkg::XLEN,
  parameter logic [31:0] NOP  = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  if_id_op_t       op,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            if_valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic            valid
);

  // Invalid fetch data is replaced by the NOP so garbage never enters decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      instr <= NOP;
      valid <= 1'b0;
    end else begin
      case (op)
        OP_LOAD: begin
          pc    <= if_pc;
          instr <= if_valid ? if_instr : NOP;
          valid <= if_valid;
        end
        OP_FLUSH: begin
          pc    <= '0;
          instr <= NOP;
          valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush/freeze controller for the 5-stage core; owns IF/ID.
module pipe_stall_ctrl
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = core_pkg::XLEN,
  parameter int unsigned CNT_W = 32,
  parameter logic [31:0] NOP   = NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_use_stall,
  input  logic             br_taken,
  input  logic             mem_busy,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      if_instr,
  input  logic             if_valid,
  output logic             pc_we,
  output logic             freeze,
  output logic             id_ex_bubble,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  stall_state_t     state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             do_stall, do_flush;
  if_id_op_t        op;

  // Priority: memory freeze, then flush (live or deferred), then load-use, else advance.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pc_we        = 1'b0;
    freeze       = 1'b0;
    id_ex_bubble = 1'b0;
    op           = OP_HOLD;
    do_stall     = 1'b0;
    do_flush     = 1'b0;
    if (!rst_n) begin
      freeze = 1'b1;
    end else if (mem_busy) begin
      freeze  = 1'b1;
      state_d = ST_FRZ;
      if (br_taken) pend_d = 1'b1;
    end else if (br_taken || pend_q) begin
      pc_we        = 1'b1;
      id_ex_bubble = 1'b1;
      op           = OP_FLUSH;
      pend_d       = 1'b0;
      do_flush     = 1'b1;
      state_d      = ST_RUN;
    end else if ((state_q == ST_RUN) && ld_use_stall) begin
      id_ex_bubble = 1'b1;
      do_stall     = 1'b1;
      state_d      = ST_LU;
    end else begin
      pc_we   = 1'b1;
      op      = OP_LOAD;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Performance counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (do_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (do_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  if_id_reg #(
    .XLEN (XLEN),
    .NOP  (NOP)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .if_pc    (if_pc),
    .if_instr (if_instr),
    .if_valid (if_valid),
    .pc       (if_id_pc),
    .instr    (if_id_instr),
    .valid    (if_id_valid)
  );

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed vector table, reset/saturation sequences, random vs model.
module tb_pipe_stall_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int A_ADV = 0, A_STALL = 1, A_FLUSH = 2, A_FRZ = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_use_stall, br_taken, mem_busy, if_valid;
  logic [31:0] if_pc, if_instr;
  logic        pc_we, freeze, id_ex_bubble, if_id_valid;
  logic [31:0] if_id_pc, if_id_instr, stall_cnt, flush_cnt;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ld_use_stall(ld_use_stall), .br_taken(br_taken),
    .mem_busy(mem_busy), .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .pc_we(pc_we), .freeze(freeze), .id_ex_bubble(id_ex_bubble),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ldu, br, mb, valid;
    logic [31:0] pc, instr;
    bit          e_pcwe, e_frz, e_bub;
    logic [31:0] e_pc, e_instr;
    bit          e_valid;
    logic [1:0]  e_state;
    logic [31:0] e_sc, e_fc;
  } tvec_t;

  // Reference model: remembers what the pipe did last cycle, not an FSM encoding.
  int          m_prev;
  bit          m_pend;
  logic [31:0] m_pc, m_instr, m_sc, m_fc;
  bit          m_valid;

  function automatic tvec_t mk(bit ldu, bit br, bit mb, logic [31:0] pc, logic [31:0] instr,
                               bit valid, bit pwe, bit frz, bit bub, logic [31:0] epc,
                               logic [31:0] einstr, bit evalid, logic [1:0] st,
                               logic [31:0] sc, logic [31:0] fc);
    tvec_t v;
    v.ldu = ldu; v.br = br; v.mb = mb; v.pc = pc; v.instr = instr; v.valid = valid;
    v.e_pcwe = pwe; v.e_frz = frz; v.e_bub = bub; v.e_pc = epc; v.e_instr = einstr;
    v.e_valid = evalid; v.e_state = st; v.e_sc = sc; v.e_fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = A_ADV; m_pend = 1'b0;
    m_pc = '0; m_instr = NOP; m_valid = 1'b0; m_sc = '0; m_fc = '0;
  endtask

  function automatic int decide(bit ldu, bit br, bit mb);
    if (mb) return A_FRZ;
    if (br || m_pend) return A_FLUSH;
    if (ldu && m_prev != A_STALL && m_prev != A_FRZ) return A_STALL;
    return A_ADV;
  endfunction

  task automatic model_update(input int act, input tvec_t v);
    case (act)
      A_FRZ:   m_pend = m_pend | v.br;
      A_FLUSH: begin
        m_pend = 1'b0; m_pc = '0; m_instr = NOP; m_valid = 1'b0;
        if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      end
      A_STALL: if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      default: begin
        m_pc = v.pc; m_instr = v.valid ? v.instr : NOP; m_valid = v.valid;
      end
    endcase
    m_prev = act;
  endtask

  function automatic logic [1:0] m_state();
    return (m_prev == A_FRZ) ? 2'd2 : (m_prev == A_STALL) ? 2'd1 : 2'd0;
  endfunction

  // One clock: drive at negedge, check combinational controls, then registered state.
  task automatic step(input tvec_t v, input bit use_tab);
    int act;
    @(negedge clk);
    ld_use_stall = v.ldu; br_taken = v.br; mem_busy = v.mb;
    if_pc = v.pc; if_instr = v.instr; if_valid = v.valid;
    #1;
    act = decide(v.ldu, v.br, v.mb);
    chk("pc_we",        32'(pc_we),        32'((act == A_ADV) || (act == A_FLUSH)));
    chk("freeze",       32'(freeze),       32'(act == A_FRZ));
    chk("id_ex_bubble", 32'(id_ex_bubble), 32'((act == A_STALL) || (act == A_FLUSH)));
    if (use_tab) begin
      chk("tab_pc_we",  32'(pc_we),        32'(v.e_pcwe));
      chk("tab_freeze", 32'(freeze),       32'(v.e_frz));
      chk("tab_bubble", 32'(id_ex_bubble), 32'(v.e_bub));
    end
    @(posedge clk);
    model_update(act, v);
    #1;
    chk("if_id_pc",    if_id_pc,           m_pc);
    chk("if_id_instr", if_id_instr,        m_instr);
    chk("if_id_valid", 32'(if_id_valid),   32'(m_valid));
    chk("stall_cnt",   stall_cnt,          m_sc);
    chk("flush_cnt",   flush_cnt,          m_fc);
    chk("state",       32'(state),         32'(m_state()));
    if (use_tab) begin
      chk("tab_if_id_pc",    if_id_pc,         v.e_pc);
      chk("tab_if_id_instr", if_id_instr,      v.e_instr);
      chk("tab_if_id_valid", 32'(if_id_valid), 32'(v.e_valid));
      chk("tab_state",       32'(state),       32'(v.e_state));
      chk("tab_stall_cnt",   stall_cnt,        v.e_sc);
      chk("tab_flush_cnt",   flush_cnt,        v.e_fc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc_we"},  32'(pc_we),        32'(0));
    chk({tag, "_freeze"}, 32'(freeze),       32'(1));
    chk({tag, "_bubble"}, 32'(id_ex_bubble), 32'(0));
    chk({tag, "_pc"},     if_id_pc,          32'(0));
    chk({tag, "_instr"},  if_id_instr,       NOP);
    chk({tag, "_valid"},  32'(if_id_valid),  32'(0));
    chk({tag, "_scnt"},   stall_cnt,         32'(0));
    chk({tag, "_fcnt"},   flush_cnt,         32'(0));
    chk({tag, "_state"},  32'(state),        32'(0));
  endtask

  tvec_t tab [18];
  tvec_t r;

  initial begin
    rst_n = 1'b0; ld_use_stall = 0; br_taken = 0; mem_busy = 0;
    if_pc = '0; if_instr = '0; if_valid = 0;
    model_reset();

    tab[0]  = mk(0,0,0,'h100,'h00000093,1, 1,0,0,'h100,'h00000093,1,0,0,0);
    tab[1]  = mk(0,0,0,'h104,'h00100113,1, 1,0,0,'h104,'h00100113,1,0,0,0);
    tab[2]  = mk(0,0,0,'h108,'h00208133,1, 1,0,0,'h108,'h00208133,1,0,0,0);
    tab[3]  = mk(0,0,0,'h10c,'h0000A083,1, 1,0,0,'h10c,'h0000A083,1,0,0,0);
    tab[4]  = mk(1,0,0,'h110,'h002081B3,1, 0,0,1,'h10c,'h0000A083,1,1,1,0);
    tab[5]  = mk(1,0,0,'h110,'h002081B3,1, 1,0,0,'h110,'h002081B3,1,0,1,0);
    tab[6]  = mk(1,1,0,'h114,'h40000033,1, 1,0,1,'h000,NOP,0,0,1,1);
    tab[7]  = mk(0,0,0,'h200,'h00100093,1, 1,0,0,'h200,'h00100093,1,0,1,1);
    tab[8]  = mk(0,1,1,'h204,'h00200113,1, 0,1,0,'h200,'h00100093,1,2,1,1);
    tab[9]  = mk(0,0,1,'h204,'h00200113,1, 0,1,0,'h200,'h00100093,1,2,1,1);
    tab[10] = mk(0,0,1,'h204,'h00200113,1, 0,1,0,'h200,'h00100093,1,2,1,1);
    tab[11] = mk(0,0,0,'h204,'h00200113,1, 1,0,1,'h000,NOP,0,0,1,2);
    tab[12] = mk(0,0,0,'h300,'hDEADBEEF,0, 1,0,0,'h300,NOP,0,0,1,2);
    tab[13] = mk(1,0,1,'h304,'h00000113,1, 0,1,0,'h300,NOP,0,2,1,2);
    tab[14] = mk(1,0,0,'h304,'h00000113,1, 1,0,0,'h304,'h00000113,1,0,1,2);
    tab[15] = mk(1,0,0,'h308,'h00000193,1, 0,0,1,'h304,'h00000113,1,1,2,2);
    tab[16] = mk(0,0,1,'h308,'h00000193,1, 0,1,0,'h304,'h00000113,1,2,2,2);
    tab[17] = mk(0,0,0,'h308,'h00000193,1, 1,0,0,'h308,'h00000193,1,0,2,2);

    // Reset values while held in reset
    repeat (2) @(posedge clk);
    #1 check_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;

    foreach (tab[i]) step(tab[i], 1'b1);

    // Reset asserted mid-freeze with a deferred flush pending
    step(mk(0,1,1,'h400,'h00000293,1, 0,0,0,0,0,0,0,0,0), 1'b0);
    @(negedge clk);
    mem_busy = 1'b1; br_taken = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    step(mk(0,0,0,'h404,'h00000313,1, 0,0,0,0,0,0,0,0,0), 1'b0);
    chk("no_flush_after_rst", flush_cnt, 32'(0));
    chk("rst_release_valid",  32'(if_id_valid), 32'(1));

    // Stall counter saturation
    @(negedge clk) force dut.stall_cnt_q = 32'hFFFF_FFFF;
    m_sc = 32'hFFFF_FFFF;
    step(mk(0,0,0,'h408,'h00000393,1, 0,0,0,0,0,0,0,0,0), 1'b0);
    @(negedge clk) release dut.stall_cnt_q;
    step(mk(1,0,0,'h40c,'h00000413,1, 0,0,0,0,0,0,0,0,0), 1'b0);
    chk("stall_cnt_sat", stall_cnt, 32'hFFFF_FFFF);
    step(mk(0,0,0,'h40c,'h00000413,1, 0,0,0,0,0,0,0,0,0), 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = mk(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 12),
             ($urandom_range(0, 99) < 20), $urandom, $urandom,
             ($urandom_range(0, 99) < 85), 0,0,0,0,0,0,0,0,0);
      step(r, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
